// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed, XOR-checksummed byte
// stream, writes 32-bit big-endian words from address 0 upward and holds the
// CPU until the whole image is in memory and verified.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  word_end;
    logic [15:0]           count_full;
    logic [7:0]            count_hi;
    logic [15:0]           words_left;
    logic [1:0]            byte_cnt;
    logic [23:0]           partial;
    logic [7:0]            csum;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        count_full = {count_hi, byte_data};
        word_end   = (byte_cnt == 2'd3);

        case (state)
            HDR_HI, HDR_LO, PAYLOAD, CHECK: byte_ready = !reset;
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase

        accept = byte_valid && byte_ready;

        case (state)
            HDR_HI: if (accept) state_next = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (count_full == 16'd0) begin
                        state_next = CHECK;
                    end else if ({16'd0, count_full} > MAX_WORDS) begin
                        state_next = ERROR;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (accept && word_end && words_left == 16'd1) state_next = CHECK;
            CHECK: if (accept) state_next = (byte_data == csum) ? DONE : ERROR;
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = HDR_HI;
        endcase
    end

    // Datapath: header latch, word assembly, write port and running checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi   <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            partial    <= '0;
            csum       <= '0;
            wr_addr    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_HI: begin
                        count_hi <= byte_data;
                        csum     <= csum ^ byte_data;
                    end
                    HDR_LO: begin
                        words_left <= count_full;
                        csum       <= csum ^ byte_data;
                    end
                    PAYLOAD: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_end) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {partial, byte_data};
                            imem_addr  <= wr_addr;
                            wr_addr    <= wr_addr + 1'b1;
                            words_left <= words_left - 16'd1;
                        end else begin
                            partial <= {partial[15:0], byte_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
